spi_slave_core: RTL
===================

Name: spi_slave_core

Overview:
SPI peripheral (slave) end of the mode-1 link (CPOL=0, CPHA=1) driven by our SPI master core. It oversamples the external sclk, ss_n and mosi in the system clock domain. Received words go to a one-deep receive register with a valid/read handshake. Words to send come from a one-deep transmit holding register. It sits between the off-chip SPI pins and a local register/bus interface.

Parameters:
DWIDTH, 8, bits per SPI word; MSB first.
SYNC_STAGES, 2, flip-flop stages on sclk, ss_n and mosi (minimum 2).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
sclk  in  1  SPI clock from master, asynchronous to clk; idles low.
ss_n  in  1  active-low slave select, asynchronous.
mosi  in  1  serial data from master.
miso  out  1  serial data to master.
miso_oe  out  1  pad output enable; 1 only while ss_n is low (synchronized).
tx_data  in  DWIDTH  word to transmit.
tx_wr  in  1  load tx_data into the holding register; accepted only when tx_full=0.
tx_full  out  1  holding register occupied.
rx_data  out  DWIDTH  last complete received word.
rx_valid  out  1  rx_data unread.
rx_rd  in  1  consume rx_data; clears rx_valid next cycle.
overrun  out  1  sticky receive-overrun flag (see Optional Feature).

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_full=0, rx_data=0, rx_valid=0, overrun=0. Bit counter=0, shifters=0, FSM=IDLE. Mid-transfer reset aborts immediately; the holding register is emptied.
- Sync: sclk, ss_n and mosi each pass SYNC_STAGES flops. An extra register on synced sclk gives rise/fall strobes, each one clk wide.
- Timing requirement: sclk high and low phases each ≥ SYNC_STAGES+2 clk cycles. A faster sclk is unsupported and undefined.
- FSM IDLE: synced ss_n=1, miso_oe=0, bit_cnt=0. A synced ss_n fall moves to ACTIVE. On entry, tx_shift loads the holding register and clears tx_full. If tx_full=0, tx_shift loads all-ones.
- ACTIVE, sclk rise: miso <= tx_shift[DWIDTH-1]; tx_shift shifts left by 1. Because of synchronization, miso changes SYNC_STAGES+1 clk cycles after the pin edge.
- ACTIVE, sclk fall: rx_shift <= {rx_shift[DWIDTH-2:0], mosi_sync}; bit_cnt increments.
- Word completion: on the fall where bit_cnt==DWIDTH-1:
  - rx_data <= assembled word; rx_valid <= 1; bit_cnt <= 0.
  - tx_shift reloads from the holding register (all-ones if empty) and tx_full clears, so back-to-back words need no ss_n toggle.
- rx_valid rises SYNC_STAGES+1 clk cycles after the last falling sclk pin edge.
- ACTIVE, ss_n rise (synced): go to IDLE next cycle. A partial word is discarded with no rx_valid. miso_oe=0 and miso=0. A word already moved into tx_shift counts as consumed.
- tx_wr while tx_full=1 is ignored. tx_wr in the same cycle as a reload: the reload takes the old contents, and the new word is stored with tx_full=1.
- rx_rd while rx_valid=0 is ignored. A completion in the same cycle as rx_rd: the new word wins and rx_valid stays 1.
- A completion while rx_valid=1 (no rx_rd) overwrites rx_data.

Optional Feature:
Macro SPI_SLAVE_OVERRUN_EN.
- Defined: overrun is set when a word completes while rx_valid=1 and rx_rd=0. It stays set until rst, or until the first rx_rd after it is set (clear takes effect the next cycle). Set has priority over clear in the same cycle.
- Undefined: overrun is tied to 0 and no flag logic is built. Overwrite behaviour is unchanged.

Decomposition:
- Shared package spi_pkg: SPI mode localparams (CPOL=0, CPHA=1), default DWIDTH, slave FSM state enum {IDLE, ACTIVE}, MISO idle-fill constant (all-ones). The master core uses the same package.
- One sub-module, spi_sync_edge: a SYNC_STAGES synchronizer plus rise/fall strobes. Instantiated for sclk and ss_n; mosi uses the synchronizer only.

Test Plan:
- Single word: tx_wr 0xA5, master sends 0x3C with half-period 5 clk. Expect miso bits 1,0,1,0,0,1,0,1, rx_data=0x3C, rx_valid=1 once, tx_full=0.
- Back-to-back: preload 0x81, load 0x7E after the first reload, two words with ss_n held low (mosi 0x12, 0x34). Expect rx 0x12 then 0x34, miso sends 0x81 then 0x7E, and exactly one reload per word.
- Underrun: no tx_wr, one 8-bit transfer. Expect miso=0xFF pattern and rx still correct.
- Abort: ss_n deasserted after 5 falls. Expect no rx_valid and bit_cnt back to 0. The next full transfer receives 0x55 correctly.
- Overrun (macro on): two words received without rx_rd. Expect rx_data = second word, overrun=1, and overrun=0 the cycle after rx_rd. With macro off, overrun stays 0.
- Reset mid-word: rst for 1 cycle after 3 bits. Expect every output at its reset value. The next transfer completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI mode constants, defaults and slave FSM states
package spi_pkg;
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b1;
  localparam int DEF_DWIDTH = 8;
  localparam bit MISO_FILL = 1'b1;
  typedef enum logic {IDLE, ACTIVE} slave_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with one-clk rise/fall strobes
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic prev;
  // shift the async input through the chain; one extra flop for edge detection
  always_ff @(posedge clk)
    if (rst) begin
      sr <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  assign rise = sr[STAGES-1] & ~prev;
  assign fall = ~sr[STAGES-1] & prev;
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: mode-1 SPI slave with 1-deep tx holding and rx registers; SPI_SLAVE_OVERRUN_EN adds a sticky overrun flag
module spi_slave_core import spi_pkg::*; #(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rd,
  output logic              overrun
);
  localparam int CW = $clog2(DWIDTH);
  localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);
  localparam logic [DWIDTH-1:0] FILL = {DWIDTH{MISO_FILL}};
  slave_state_e state, state_n;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [CW-1:0] bit_cnt;
  logic [DWIDTH-1:0] tx_shift, tx_hold, rx_shift, rx_word;
  logic act, done, reload, tx_acc;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .d(ss_n), .rise(ss_rise), .fall(ss_fall)
  );
  // mosi only needs the synchronizer so it stays aligned with the sclk strobes
  always_ff @(posedge clk)
    if (rst) mosi_sr <= '0;
    else mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
  assign act = (state == ACTIVE) & ~ss_rise;
  assign done = act & sclk_fall & (bit_cnt == LAST);
  assign reload = ((state == IDLE) & ss_fall) | done;
  assign tx_acc = tx_wr & ~tx_full;
  assign rx_word = {rx_shift[DWIDTH-2:0], mosi_sr[SYNC_STAGES-1]};
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // select edges move between idle and active; pad drives only while active
  always_comb begin
    state_n = state;
    miso_oe = state == ACTIVE;
    if (state == IDLE && ss_fall) state_n = ACTIVE;
    if (state == ACTIVE && ss_rise) state_n = IDLE;
  end
  // transmit side: holding register and shifter, reloaded at select and at each word end
  always_ff @(posedge clk)
    if (rst) begin
      tx_hold <= '0;
      tx_full <= 1'b0;
      tx_shift <= '0;
      miso <= 1'b0;
    end else begin
      if (tx_acc) tx_hold <= tx_data;
      tx_full <= tx_acc | (tx_full & ~reload);
      if (reload) tx_shift <= tx_full ? tx_hold : FILL;
      else if (act & sclk_rise) tx_shift <= {tx_shift[DWIDTH-2:0], 1'b0};
      if (state == ACTIVE && ss_rise) miso <= 1'b0;
      else if (act & sclk_rise) miso <= tx_shift[DWIDTH-1];
    end
  // receive side: sample on falling sclk, hand complete words to the rx register
  always_ff @(posedge clk)
    if (rst) begin
      bit_cnt <= '0;
      rx_shift <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (state == ACTIVE && ss_rise) begin
        bit_cnt <= '0;
        rx_shift <= '0;
      end else if (act & sclk_fall) begin
        bit_cnt <= done ? '0 : bit_cnt + 1'b1;
        rx_shift <= rx_word;
      end
      if (done) rx_data <= rx_word;
      rx_valid <= done | (rx_valid & ~rx_rd);
    end
`ifdef SPI_SLAVE_OVERRUN_EN
  // sticky overrun: set when a word lands on unread data, cleared by a read
  always_ff @(posedge clk)
    if (rst) overrun <= 1'b0;
    else overrun <= (done & rx_valid & ~rx_rd) | (overrun & ~rx_rd);
`else
  assign overrun = 1'b0;
`endif
endmodule
